sub_serial: RTL
===============

# sub_serial

Bit-serial subtractor for the serial arithmetic datapath. It captures two W-bit operands on `en` and computes `a - b` one bit per clock, LSB first, using a borrow flip-flop. The difference shifts into a parallel output register, and the final borrow (underflow) is reported. It is the inverse-operation counterpart of the serial adder and shares that block's `en`/IDLE→compute→DONE handshake, so the two can be used interchangeably by the same controller.

## Interface
- `W`, default 8: operand and result width, W ≥ 2.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: start request in IDLE; acknowledge/release in DONE.
- `a`, input, W: minuend, sampled only on the load edge.
- `b`, input, W: subtrahend, sampled only on the load edge.
- `out`, output, W: difference register; shifts MSB-in during SUB.
- `borrow_out`, output, 1: final borrow, 1 means a < b (unsigned).
- `done`, output, 1: high while in DONE; `out` and `borrow_out` are valid.
- `busy`, output, 1: high while in SUB.

## Operation
- States: IDLE, SUB, DONE. State encoding is 2 bits; the unused code returns to IDLE on the next edge.
- Internal registers:
  - `a_reg`, `b_reg`: W bits each.
  - `borrow`: 1 bit.
  - `count`: $clog2(W) bits.
- IDLE:
  - If `en`=1: load `a_reg`←`a`, `b_reg`←`b`, `borrow`←0, `count`←0, `out`←0; go to SUB.
  - Otherwise stay in IDLE; all registers hold.
- SUB, each cycle:
  - `d` = `a_reg[0]` ^ `b_reg[0]` ^ `borrow`.
  - `borrow` ← (~`a_reg[0]` & `b_reg[0]`) | (~`a_reg[0]` & `borrow`) | (`b_reg[0]` & `borrow`).
  - `out` ← {`d`, `out[W-1:1]`}.
  - `a_reg` and `b_reg` shift right by 1, zero fill.
  - `count`++.
  - When `count`==W-1: latch `borrow_out` ← next borrow and go to DONE.
  - `en` is ignored in SUB.
- DONE:
  - `out` and `borrow_out` hold.
  - `en`=1 → IDLE; `en`=0 → stay in DONE.
- Arithmetic: result = (a - b) mod 2^W; `borrow_out` is the unsigned underflow.
- `borrow_out` is cleared on the load edge and holds otherwise.

## Timing
- Reset (`rst_n`=0, asynchronous, any cycle including mid-SUB) forces:
  - state = IDLE;
  - `out` = 0, `borrow_out` = 0, `done` = 0, `busy` = 0;
  - all internal registers = 0.
- Load edge E (IDLE with `en`=1): `busy`=1 from E.
- Shift edges: E+1 … E+W.
- At edge E+W: state becomes DONE and `done`=1. Latency from the load edge to a valid result is W clocks.
- `en` held high continuously:
  - DONE → IDLE at the next edge, then reload at the following edge.
  - Restart period is W+2 cycles.
  - `out` is cleared at each reload.
- `done` and `busy` are decoded directly from state registers (registered outputs, no combinational path from `en`).
- `a` and `b` may change freely after edge E.

## Structure
- Shared package `serial_arith_pkg`:
  - state enum (`IDLE`, `SUB`, `DONE`);
  - `DEFAULT_W` = 8.
  - The serial adder is to share the same package.
- One sub-module, `full_sub_bit`: combinational 1-bit full subtractor with inputs `x`, `y`, `bin` and outputs `d`, `bout`.
- FSM, shift registers and counter live in `sub_serial`.

## Test plan
- Basic subtraction: reset, then `a`=100, `b`=37, pulse `en`. At edge E+8, `done`=1, `out`=63, `borrow_out`=0.
- Underflow: `a`=5, `b`=9. Result `out`=8'hFC (252), `borrow_out`=1.
- Edge cases:
  - 0-0 → `out`=0, borrow 0.
  - 0-1 → `out`=255, borrow 1.
  - 255-255 → `out`=0, borrow 0.
- Operand independence: change `a`/`b` every cycle during SUB. The result still matches the operands captured at edge E; the `en` toggling in SUB is ignored.
- Reset mid-operation: assert `rst_n`=0 at E+4.
  - All outputs read 0 immediately, state is IDLE.
  - After release, a new 200-55 run gives `out`=145, borrow 0.
- Back-to-back runs: hold `en`=1 across two operand pairs.
  - `done` pulses for one cycle each run.
  - Period is 10 cycles (W=8).
  - Second result is correct. Also run with W=16: 1000-2000 → 64536, borrow 1.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial adder/subtractor datapath.
// Both serial blocks use the same state set and default width.
package serial_arith_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/full_sub_bit.sv
// One-bit full subtractor: d = x - y - bin, bout set on underflow.
// Purely combinational; the borrow flop lives in the caller.
module full_sub_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Difference shifts in at the MSB; final borrow flags a < b.
module sub_serial
  import serial_arith_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] out,
  output logic         borrow_out,
  output logic         done,
  output logic         busy
);

  localparam int CW = $clog2(W);

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    out_q;
  logic [CW-1:0]   count_q;
  logic            borrow_q;
  logic            borrow_out_q;

  logic            bit_d;
  logic            borrow_d;

  full_sub_bit u_fsb (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (borrow_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      out_q        <= '0;
      count_q      <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            a_q          <= a;
            b_q          <= b;
            out_q        <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            state_q      <= SUB;
          end
        end
        SUB: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          out_q    <= {bit_d, out_q[W-1:1]};
          borrow_q <= borrow_d;
          count_q  <= count_q + CW'(1);
          if (count_q == CW'(W - 1)) begin
            borrow_out_q <= borrow_d;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (en) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign borrow_out = borrow_out_q;
  assign done       = (state_q == DONE);
  assign busy       = (state_q == SUB);

endmodule
